// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register byte offsets,
// bus FSM state encoding and byte-lane mask helper.
package gpio_pkg;

    localparam logic [4:0] OFS_OUT     = 5'h00;
    localparam logic [4:0] OFS_OE      = 5'h04;
    localparam logic [4:0] OFS_IN      = 5'h08;
    localparam logic [4:0] OFS_RISE_EN = 5'h0C;
    localparam logic [4:0] OFS_FALL_EN = 5'h10;
    localparam logic [4:0] OFS_STATUS  = 5'h14;
    localparam logic [4:0] OFS_OUT_SET = 5'h18;
    localparam logic [4:0] OFS_OUT_CLR = 5'h1C;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_RESP = 1'b1
    } bus_state_e;

    // Expands a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_if.sv
// Simple valid/ready register bus between a master and the GPIO controller.
interface gpio_if;
    logic        bus_valid;
    logic        bus_ready;
    logic [4:0]  bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/gpio_sync.sv
// Multi-stage synchronizer for asynchronous pad inputs, followed by a
// one-cycle history register used to derive rising and falling edges.
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    // Next-state of the shift chain and the history register.
    always_comb begin
        stage_d[0] = pin_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        prev_d = stage_q[SYNC_STAGES-1];
    end

    // Synchronizer and history flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
            prev_q <= prev_d;
        end
    end

    assign sync = stage_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: register file behind a two-state valid/ready bus,
// pad output/enable drive and edge-triggered level interrupt.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    gpio_if.slave            bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    bus_state_e       state_q, state_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;

    logic [WIDTH-1:0] sync_s, rise_s, fall_s;
    logic [WIDTH-1:0] set_ev_s, status_clr_s;
    logic [WIDTH-1:0] wmask_s, wbits_s;
    logic [31:0]      lane_s;
    logic [31:0]      rd_s;
    logic [4:0]       reg_ofs_s;
    logic             wr_en_s;
    logic             unused_s;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .pin_in (gpio_in),
        .sync   (sync_s),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    assign reg_ofs_s = {bus.bus_addr[4:2], 2'b00};
    assign lane_s    = lane_mask(bus.bus_wstrb);
    assign wmask_s   = lane_s[WIDTH-1:0];
    assign wbits_s   = bus.bus_wdata[WIDTH-1:0] & wmask_s;
    assign wr_en_s   = (state_q == BUS_RESP) && (bus.bus_wstrb != 4'b0000);
    assign set_ev_s  = (rise_s & rise_en_q) | (fall_s & fall_en_q);
    assign unused_s  = ^{bus.bus_addr[1:0], bus.bus_wdata, lane_s};

    // Read mux; bits at or above WIDTH and write-only registers read zero.
    always_comb begin
        rd_s = '0;
        case (reg_ofs_s)
            OFS_OUT:     rd_s[WIDTH-1:0] = out_q;
            OFS_OE:      rd_s[WIDTH-1:0] = oe_q;
            OFS_IN:      rd_s[WIDTH-1:0] = sync_s;
            OFS_RISE_EN: rd_s[WIDTH-1:0] = rise_en_q;
            OFS_FALL_EN: rd_s[WIDTH-1:0] = fall_en_q;
            OFS_STATUS:  rd_s[WIDTH-1:0] = status_q;
            default:     rd_s = '0;
        endcase
    end

    // Bus FSM next state; read data is captured on entry to RESP and zero otherwise.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = '0;
        case (state_q)
            BUS_IDLE: begin
                if (bus.bus_valid) begin
                    state_d = BUS_RESP;
                    ready_d = 1'b1;
                    rdata_d = rd_s;
                end else begin
                    state_d = BUS_IDLE;
                end
            end
            BUS_RESP: state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    // Register writes commit at the edge that ends RESP; the master still holds the request.
    always_comb begin
        out_d        = out_q;
        oe_d         = oe_q;
        rise_en_d    = rise_en_q;
        fall_en_d    = fall_en_q;
        status_clr_s = '0;
        if (wr_en_s) begin
            case (reg_ofs_s)
                OFS_OUT:     out_d        = (out_q & ~wmask_s) | wbits_s;
                OFS_OE:      oe_d         = (oe_q & ~wmask_s) | wbits_s;
                OFS_RISE_EN: rise_en_d    = (rise_en_q & ~wmask_s) | wbits_s;
                OFS_FALL_EN: fall_en_d    = (fall_en_q & ~wmask_s) | wbits_s;
                OFS_STATUS:  status_clr_s = wbits_s;
                OFS_OUT_SET: out_d        = out_q | wbits_s;
                OFS_OUT_CLR: out_d        = out_q & ~wbits_s;
                default:     out_d        = out_q;
            endcase
        end else begin
            out_d = out_q;
        end
        // A coincident edge event beats a W1C so no interrupt is lost.
        status_d = (status_q & ~status_clr_s) | set_ev_s;
    end

    // Bus FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= BUS_IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
        end
    end

    assign bus.bus_ready = ready_q;
    assign bus.bus_rdata = rdata_q;
    assign gpio_out      = out_q;
    assign gpio_oe       = oe_q;
    assign irq           = |status_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: table-driven register vectors, a read-data
// scoreboard, edge/interrupt timing sequences, reset abort and a WIDTH=4 instance.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    gpio_if bif8();
    gpio_if bif4();

    logic        sel_s   = 1'b0;
    logic        valid_s = 1'b0;
    logic [4:0]  addr_s  = 5'h00;
    logic [3:0]  wstrb_s = 4'h0;
    logic [31:0] wdata_s = 32'h0;

    assign bif8.bus_valid = valid_s & ~sel_s;
    assign bif8.bus_addr  = addr_s;
    assign bif8.bus_wstrb = wstrb_s;
    assign bif8.bus_wdata = wdata_s;
    assign bif4.bus_valid = valid_s & sel_s;
    assign bif4.bus_addr  = addr_s;
    assign bif4.bus_wstrb = wstrb_s;
    assign bif4.bus_wdata = wdata_s;

    logic [7:0] gpio_in8 = 8'h00;
    logic [7:0] gpio_out8, gpio_oe8;
    logic       irq8;
    logic [3:0] gpio_in4 = 4'h0;
    logic [3:0] gpio_out4, gpio_oe4;
    logic       irq4;

    gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .resetn(resetn), .bus(bif8),
        .gpio_in(gpio_in8), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    gpio_ctrl #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .resetn(resetn), .bus(bif4),
        .gpio_in(gpio_in4), .gpio_out(gpio_out4), .gpio_oe(gpio_oe4), .irq(irq4)
    );

    wire        cur_ready = sel_s ? bif4.bus_ready : bif8.bus_ready;
    wire [31:0] cur_rdata = sel_s ? bif4.bus_rdata : bif8.bus_rdata;

    typedef struct {
        logic [31:0] exp;
        bit          chk;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [4:0]  addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          chk;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
    } vec_t;
    vec_t vecs[18];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: pops one expectation per completion, rdata must be 0 when idle.
    always @(negedge clk) begin
        sb_t e;
        if (resetn) begin
            if (cur_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk) check("rdata", cur_rdata, e.exp);
                end
            end else begin
                check("rdata_idle", cur_rdata, 32'd0);
            end
        end
    end

    task automatic bus_xfer(input string name, input logic [4:0] a, input logic [3:0] s,
                            input logic [31:0] d, input logic [31:0] exp, input bit chk);
        sb_t e;
        int  n;
        e.exp = exp;
        e.chk = chk;
        @(posedge clk); #1;
        addr_s  = a;
        wstrb_s = s;
        wdata_s = d;
        valid_s = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        check({name, "_latency"}, {31'd0, cur_ready}, 32'd1);
        n = 0;
        while (!cur_ready && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cur_ready) begin
            check({name, "_timeout"}, {31'd0, cur_ready}, 32'd1);
            if (sb_q.size() > 0) e = sb_q.pop_back();
        end
        @(posedge clk); #1;
        valid_s = 1'b0;
        wstrb_s = 4'h0;
        check({name, "_ready_pulse"}, {31'd0, cur_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{5'h00, 4'b0001, 32'h0000_005A, 32'h0000_0000, 1'b0, 8'h5A, 8'h00};
        vecs[1]  = '{5'h00, 4'b0000, 32'h0000_0000, 32'h0000_005A, 1'b1, 8'h5A, 8'h00};
        vecs[2]  = '{5'h00, 4'b1110, 32'hA5A5_A500, 32'h0000_0000, 1'b0, 8'h5A, 8'h00};
        vecs[3]  = '{5'h00, 4'b0000, 32'h0000_0000, 32'h0000_005A, 1'b1, 8'h5A, 8'h00};
        vecs[4]  = '{5'h00, 4'b0001, 32'h0000_000F, 32'h0000_0000, 1'b0, 8'h0F, 8'h00};
        vecs[5]  = '{5'h18, 4'b1111, 32'h0000_0030, 32'h0000_0000, 1'b0, 8'h3F, 8'h00};
        vecs[6]  = '{5'h1C, 4'b1111, 32'h0000_0001, 32'h0000_0000, 1'b0, 8'h3E, 8'h00};
        vecs[7]  = '{5'h00, 4'b0000, 32'hFFFF_FFFF, 32'h0000_003E, 1'b1, 8'h3E, 8'h00};
        vecs[8]  = '{5'h04, 4'b0001, 32'h1234_560F, 32'h0000_0000, 1'b0, 8'h3E, 8'h0F};
        vecs[9]  = '{5'h04, 4'b0010, 32'h0000_FF00, 32'h0000_0000, 1'b0, 8'h3E, 8'h0F};
        vecs[10] = '{5'h05, 4'b0000, 32'h0000_0000, 32'h0000_000F, 1'b1, 8'h3E, 8'h0F};
        vecs[11] = '{5'h08, 4'b1111, 32'h0000_00FF, 32'h0000_0000, 1'b0, 8'h3E, 8'h0F};
        vecs[12] = '{5'h18, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 8'h3E, 8'h0F};
        vecs[13] = '{5'h1C, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 8'h3E, 8'h0F};
        vecs[14] = '{5'h0C, 4'b0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 8'h3E, 8'h0F};
        vecs[15] = '{5'h0F, 4'b0000, 32'h0000_0000, 32'h0000_0001, 1'b1, 8'h3E, 8'h0F};
        vecs[16] = '{5'h14, 4'b1111, 32'h0000_00FF, 32'h0000_0000, 1'b0, 8'h3E, 8'h0F};
        vecs[17] = '{5'h08, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 8'h3E, 8'h0F};

        // Reset state
        #12;
        check("rst_ready", {31'd0, bif8.bus_ready}, 32'd0);
        check("rst_rdata", bif8.bus_rdata, 32'd0);
        check("rst_out", {24'd0, gpio_out8}, 32'd0);
        check("rst_oe", {24'd0, gpio_oe8}, 32'd0);
        check("rst_irq", {31'd0, irq8}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            bus_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wstrb, vecs[i].wdata,
                     vecs[i].exp_rdata, vecs[i].chk);
            check($sformatf("vec%0d_out", i), {24'd0, gpio_out8}, {24'd0, vecs[i].exp_out});
            check($sformatf("vec%0d_oe", i), {24'd0, gpio_oe8}, {24'd0, vecs[i].exp_oe});
        end

        // Rising edge on pin 0 reaches STATUS/irq exactly 3 cycles later
        @(posedge clk); #1;
        gpio_in8[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rise_irq_c%0d", k), {31'd0, irq8}, (k == 3) ? 32'd1 : 32'd0);
        end
        bus_xfer("rd_status_rise", 5'h14, 4'b0000, 32'h0, 32'h0000_0001, 1'b1);
        bus_xfer("w1c_rise", 5'h14, 4'b0001, 32'h0000_0001, 32'h0, 1'b0);
        check("irq_after_w1c", {31'd0, irq8}, 32'd0);
        bus_xfer("rd_status_clr", 5'h14, 4'b0000, 32'h0, 32'h0, 1'b1);
        bus_xfer("rd_in", 5'h08, 4'b0000, 32'h0, 32'h0000_0001, 1'b1);

        // Fall on pin 7 lands in the same cycle as a W1C of bit 7
        bus_xfer("wr_fall_en", 5'h10, 4'b0001, 32'h0000_0080, 32'h0, 1'b0);
        gpio_in8[7] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_rise7_irq", {31'd0, irq8}, 32'd0);
        @(posedge clk); #1;
        gpio_in8[7] = 1'b0;
        bus_xfer("w1c_race", 5'h14, 4'b0001, 32'h0000_0080, 32'h0, 1'b0);
        check("race_irq", {31'd0, irq8}, 32'd1);
        bus_xfer("rd_status_race", 5'h14, 4'b0000, 32'h0, 32'h0000_0080, 1'b1);
        bus_xfer("clr_fall_en", 5'h10, 4'b0001, 32'h0, 32'h0, 1'b0);
        bus_xfer("rd_status_keep", 5'h14, 4'b0000, 32'h0, 32'h0000_0080, 1'b1);
        bus_xfer("w1c_7", 5'h14, 4'b0001, 32'h0000_0080, 32'h0, 1'b0);
        bus_xfer("rd_status_end", 5'h14, 4'b0000, 32'h0, 32'h0, 1'b1);
        check("irq_end", {31'd0, irq8}, 32'd0);

        // Reset during RESP of OE=0xFF write abandons it
        check("pre_abort_oe", {24'd0, gpio_oe8}, 32'h0000_000F);
        @(posedge clk); #1;
        addr_s  = 5'h04;
        wstrb_s = 4'b0001;
        wdata_s = 32'h0000_00FF;
        valid_s = 1'b1;
        @(posedge clk); #1;
        check("abort_in_resp", {31'd0, bif8.bus_ready}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("abort_ready", {31'd0, bif8.bus_ready}, 32'd0);
        check("abort_rdata", bif8.bus_rdata, 32'd0);
        check("abort_oe", {24'd0, gpio_oe8}, 32'd0);
        check("abort_out", {24'd0, gpio_out8}, 32'd0);
        valid_s = 1'b0;
        wstrb_s = 4'h0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        bus_xfer("rd_oe_after_rst", 5'h04, 4'b0000, 32'h0, 32'h0, 1'b1);
        check("oe_after_rst", {24'd0, gpio_oe8}, 32'd0);

        // WIDTH=4 instance
        sel_s = 1'b1;
        bus_xfer("w4_wr_out", 5'h00, 4'b1111, 32'h0000_00FF, 32'h0, 1'b0);
        check("w4_gpio_out", {28'd0, gpio_out4}, 32'h0000_000F);
        bus_xfer("w4_rd_out", 5'h00, 4'b0000, 32'h0, 32'h0000_000F, 1'b1);
        bus_xfer("w4_rd_set", 5'h18, 4'b0000, 32'h0, 32'h0, 1'b1);
        sel_s = 1'b0;

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO pins (legal range 1..32).
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth (legal values >=2).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 bus_valid  input  1  request present; held by the master until bus_ready.
REQ-006 bus_ready  output  1  single-cycle completion strobe.
REQ-007 bus_addr  input  5  byte address; bits [4:2] select the register, bits [1:0] are ignored.
REQ-008 bus_wstrb  input  4  byte-lane write enables; 4'b0000 means read.
REQ-009 bus_wdata  input  32  write data.
REQ-010 bus_rdata  output  32  read data, valid only while bus_ready is high.
REQ-011 gpio_in  input  WIDTH  raw pad inputs, asynchronous to clk.
REQ-012 gpio_out  output  WIDTH  pad output values.
REQ-013 gpio_oe  output  WIDTH  pad output enables, 1 = drive; the tristate buffer sits in the top level.
REQ-014 irq  output  1  level interrupt.

Function
REQ-015 Register map:
- 0x00 OUT (rw)
- 0x04 OE (rw)
- 0x08 IN (ro, synchronized pins)
- 0x0C RISE_EN (rw)
- 0x10 FALL_EN (rw)
- 0x14 STATUS (rw1c)
- 0x18 OUT_SET (wo, 1 sets OUT bit)
- 0x1C OUT_CLR (wo, 1 clears OUT bit)
REQ-016 Bus FSM states:
- IDLE: bus_valid=1 -> RESP.
- RESP: bus_ready=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-017 Latency: bus_ready rises on the cycle after bus_valid is first sampled in IDLE; back-to-back requests therefore complete at most every 2 cycles.
REQ-018 Writes commit on the clock edge ending the RESP cycle; only lanes with bus_wstrb set are written.
REQ-019 Read data:
- Register bits at or above WIDTH read 0 and ignore writes.
- Write-only registers (OUT_SET, OUT_CLR) read 0.
- bus_rdata=0 whenever bus_ready=0.
REQ-020 gpio_out mirrors OUT and gpio_oe mirrors OE, direct from registers with no added latency.
REQ-021 IN = the last synchronizer stage; pin-to-IN latency is SYNC_STAGES cycles.
REQ-022 Edge detection compares the synchronized value against its one-cycle-delayed copy:
- rise = cur & ~prev
- fall = ~cur & prev
REQ-023 STATUS[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); pin-to-STATUS latency is SYNC_STAGES+1 cycles.
REQ-024 A write of 1 to a STATUS bit clears it; if a set event occurs in the same cycle as the clear, set wins.
REQ-025 irq = OR of all STATUS bits, combinational from STATUS, so it asserts in the same cycle a bit sets.
REQ-026 Clearing enable bits does not clear already-set STATUS bits.
REQ-027 A write to an unmapped or read-only address completes with bus_ready and has no effect.

Reset
REQ-028 On resetn=0:
- All registers and synchronizer/prev stages are 0, the FSM is in IDLE.
- bus_ready=0, bus_rdata=0, gpio_out=0, gpio_oe=0, irq=0.
REQ-029 Reset asserted mid-transaction abandons it without a write; the master must reissue.
REQ-030 Deassertion is not internally synchronized; the top level supplies a clk-synchronous release.

Structure
REQ-031 A shared package gpio_pkg holds the register offset constants and the bus FSM state enum.
REQ-032 Sub-module gpio_sync (WIDTH, SYNC_STAGES) contains the synchronizer chain plus prev register and outputs sync, rise and fall; gpio_ctrl holds the bus FSM and registers.

Verification
REQ-033 Write 0x5A to OUT with wstrb=0001, then read OUT -> gpio_out=0x5A, bus_rdata=0x0000005A, bus_ready exactly 1 cycle after valid.
REQ-034 OUT=0x0F, write OUT_SET=0x30, then OUT_CLR=0x01 -> OUT reads 0x3E.
REQ-035 RISE_EN=0x01, gpio_in[0] 0->1 -> STATUS=0x01 and irq=1 exactly 3 cycles later (SYNC_STAGES=2); write STATUS=0x01 -> irq=0.
REQ-036 FALL_EN=0x80; drive the bit-7 fall so its STATUS set lands in the same cycle as a W1C to bit 7 -> STATUS[7] remains 1.
REQ-037 Assert resetn low while in RESP of a write to OE=0xFF -> OE=0, gpio_oe=0, bus_ready=0 immediately (asynchronously).
REQ-038 WIDTH=4: write OUT=0xFF, read OUT -> 0x0000000F; read addr 0x18 -> 0.
